// File: rtl/led_cfg_pkg.sv
// Shared definitions for the LED divider configuration stage.
// Contents:
//   DIV_W, DIV_MAX - divider bus width and its saturation ceiling
//   wr_state_t     - write-FSM state encoding
//   max_u          - elaboration-time helper for sizing shared counters
package led_cfg_pkg;

    localparam int unsigned DIV_W = 5;
    localparam logic [DIV_W-1:0] DIV_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE
    } wr_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, debounce, press-edge
// detection and optional auto-repeat.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   btn_i      - raw asynchronous button level, active-high
//   event_o    - registered one-cycle step event (press or repeat tick)
module btn_debounce
    import led_cfg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_CYC   = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic event_o
);

    localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CYC, REPEAT_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit          RPT_EN  = (REPEAT_CYC != 0);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_EN ? (REPEAT_CYC - 1) : 0);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             event_q, event_d;
    logic             rpt_hit;
    logic             synced;

    assign synced = sync_q[1];

    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        // Counter only runs while the synced level disagrees with the
        // accepted level; any agreement restarts the qualification window.
        if (synced != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = synced;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rpt_cnt_d = '0;
        rpt_hit   = 1'b0;
        // Counting starts in the first cycle the stable level is high, so
        // the first repeat lands REPEAT_CYC cycles after the press event.
        if (RPT_EN && stable_q) begin
            if (rpt_cnt_q == RPT_LAST) begin
                rpt_hit = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    assign event_d = (stable_d & ~stable_q) | rpt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
            rpt_cnt_q <= '0;
            event_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            event_q   <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/led_div_cfg.sv
// Divider configuration stage for the LED counter reconfigurable region.
// Two buttons step a saturating 5-bit divider; each change is written
// downstream with a one-cycle strobe, deferred while the partition is busy.
// Ports:
//   clk100     - 100 MHz clock
//   rst_n      - asynchronous active-low reset
//   btn_up_i   - raw up button
//   btn_dn_i   - raw down button
//   pr_busy_i  - downstream partition reconfiguring; holds off writes
//   div_o      - current divider value
//   wren_o     - one-cycle write strobe
//   pend_o     - a changed value is waiting to be written
module led_div_cfg
    import led_cfg_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYC = 1000000,
    parameter int unsigned      REPEAT_CYC   = 25000000,
    parameter logic [DIV_W-1:0] DIV_RST      = 5'd16
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             btn_up_i,
    input  logic             btn_dn_i,
    input  logic             pr_busy_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o,
    output logic             pend_o
);

    logic up_ev, dn_ev;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_btn_up (
        .clk     (clk100),
        .rst_n   (rst_n),
        .btn_i   (btn_up_i),
        .event_o (up_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_btn_dn (
        .clk     (clk100),
        .rst_n   (rst_n),
        .btn_i   (btn_dn_i),
        .event_o (dn_ev)
    );

    logic [DIV_W-1:0] div_q, div_d;
    logic             change;
    wr_state_t        state_q, state_d;
    logic             wren_q, pend_q;

    // Saturated steps and simultaneous up/down leave the value untouched
    // and do not count as a change.
    always_comb begin
        div_d  = div_q;
        change = 1'b0;
        if (up_ev && !dn_ev && (div_q != DIV_MAX)) begin
            div_d  = div_q + 1'b1;
            change = 1'b1;
        end else if (dn_ev && !up_ev && (div_q != '0)) begin
            div_d  = div_q - 1'b1;
            change = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (change) begin
                    state_d = pr_busy_i ? WAIT : WRITE;
                end
            end
            WAIT: begin
                // Changes while waiting just update div_q; only the final
                // value gets written once busy drops.
                if (!pr_busy_i) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (change) begin
                    state_d = pr_busy_i ? WAIT : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // Strobe and pending flag are registered copies of the next state so
    // the outputs carry no combinational path from the inputs.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DIV_RST;
            state_q <= WAIT;
            wren_q  <= 1'b0;
            pend_q  <= 1'b1;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            wren_q  <= (state_d == WRITE);
            pend_q  <= (state_d == WAIT);
        end
    end

    assign div_o  = div_q;
    assign wren_o = wren_q;
    assign pend_o = pend_q;

endmodule

// File: tb/tb_led_div_cfg.sv
// Directed bench for led_div_cfg: one instance without auto-repeat and one
// with REPEAT_CYC=20, sharing clock, reset and inputs.
module tb_led_div_cfg;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_dn;
    logic       busy;
    logic [4:0] div;
    logic       wren;
    logic       pend;
    logic [4:0] div_r;
    logic       wren_r;
    logic       pend_r;

    int tests;
    int fails;
    int strobes;
    int strobes_r;
    logic [4:0] last_div;
    logic [4:0] last_div_r;

    led_div_cfg #(
        .DEBOUNCE_CYC (4),
        .REPEAT_CYC   (0),
        .DIV_RST      (5'd16)
    ) dut (
        .clk100    (clk),
        .rst_n     (rst_n),
        .btn_up_i  (btn_up),
        .btn_dn_i  (btn_dn),
        .pr_busy_i (busy),
        .div_o     (div),
        .wren_o    (wren),
        .pend_o    (pend)
    );

    led_div_cfg #(
        .DEBOUNCE_CYC (4),
        .REPEAT_CYC   (20),
        .DIV_RST      (5'd16)
    ) dut_rpt (
        .clk100    (clk),
        .rst_n     (rst_n),
        .btn_up_i  (btn_up),
        .btn_dn_i  (btn_dn),
        .pr_busy_i (busy),
        .div_o     (div_r),
        .wren_o    (wren_r),
        .pend_o    (pend_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitors, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            strobes  = strobes + 1;
            last_div = div;
        end
        if (wren_r === 1'b1) begin
            strobes_r  = strobes_r + 1;
            last_div_r = div_r;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        btn_up = up;
        btn_dn = dn;
        step(hold);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        step(12);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        busy   = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        step(2);
        @(negedge clk);
        tests++;
        if (div !== 5'd16) begin fails++; $display("FAIL reset_div got %0d want 16", div); end
        tests++;
        if (wren !== 1'b0) begin fails++; $display("FAIL reset_wren got %b want 0", wren); end
        tests++;
        if (pend !== 1'b1) begin fails++; $display("FAIL reset_pend got %b want 1", pend); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (wren !== 1'b1 || div !== 5'd16) begin
            fails++;
            $display("FAIL init_write got wren=%b div=%0d want wren=1 div=16", wren, div);
        end
        tests++;
        if (pend !== 1'b0) begin fails++; $display("FAIL init_pend got %b want 0", pend); end
        @(negedge clk);
        tests++;
        if (wren !== 1'b0) begin fails++; $display("FAIL init_single got wren=%b want 0", wren); end
    endtask

    task automatic test_press();
        step(2);
        strobes = 0;
        press(1'b1, 1'b0, 10);
        tests++;
        if (strobes !== 1 || last_div !== 5'd17 || div !== 5'd17) begin
            fails++;
            $display("FAIL press_up got strobes=%0d div=%0d want strobes=1 div=17", strobes, div);
        end
        strobes = 0;
        press(1'b1, 1'b0, 3);
        tests++;
        if (strobes !== 0 || div !== 5'd17) begin
            fails++;
            $display("FAIL glitch got strobes=%0d div=%0d want strobes=0 div=17", strobes, div);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 14; i++) press(1'b1, 1'b0, 10);
        tests++;
        if (div !== 5'd31) begin fails++; $display("FAIL reach_max got %0d want 31", div); end
        strobes = 0;
        press(1'b1, 1'b0, 10);
        tests++;
        if (strobes !== 0 || div !== 5'd31) begin
            fails++;
            $display("FAIL sat_up got strobes=%0d div=%0d want strobes=0 div=31", strobes, div);
        end
        for (int i = 0; i < 31; i++) press(1'b0, 1'b1, 10);
        tests++;
        if (div !== 5'd0) begin fails++; $display("FAIL reach_min got %0d want 0", div); end
        strobes = 0;
        press(1'b0, 1'b1, 10);
        tests++;
        if (strobes !== 0 || div !== 5'd0) begin
            fails++;
            $display("FAIL sat_dn got strobes=%0d div=%0d want strobes=0 div=0", strobes, div);
        end
    endtask

    task automatic test_busy();
        busy = 1'b0;
        do_reset();
        strobes = 0;
        busy = 1'b1;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
        tests++;
        if (pend !== 1'b1 || div !== 5'd19 || strobes !== 0) begin
            fails++;
            $display("FAIL busy_hold got pend=%b div=%0d strobes=%0d want 1 19 0",
                     pend, div, strobes);
        end
        @(posedge clk);
        #1;
        busy = 1'b0;
        @(negedge clk);
        tests++;
        if (wren !== 1'b0) begin fails++; $display("FAIL busy_drop_early got wren=%b want 0", wren); end
        @(negedge clk);
        tests++;
        if (wren !== 1'b1 || div !== 5'd19) begin
            fails++;
            $display("FAIL busy_drop_write got wren=%b div=%0d want 1 19", wren, div);
        end
        step(4);
        tests++;
        if (strobes !== 1 || pend !== 1'b0) begin
            fails++;
            $display("FAIL busy_single got strobes=%0d pend=%b want 1 0", strobes, pend);
        end
    endtask

    task automatic test_cancel();
        strobes = 0;
        press(1'b1, 1'b1, 10);
        tests++;
        if (strobes !== 0 || div !== 5'd19) begin
            fails++;
            $display("FAIL cancel got strobes=%0d div=%0d want 0 19", strobes, div);
        end
    endtask

    task automatic test_reset_mid();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
        tests++;
        if (pend !== 1'b1 || div !== 5'd22) begin
            fails++;
            $display("FAIL wait22 got pend=%b div=%0d want 1 22", pend, div);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (div !== 5'd16 || wren !== 1'b0 || pend !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset got div=%0d wren=%b pend=%b want 16 0 1", div, wren, pend);
        end
        step(2);
        busy = 1'b0;
    endtask

    task automatic test_repeat();
        do_reset();
        strobes_r = 0;
        btn_up = 1'b1;
        step(72);
        btn_up = 1'b0;
        step(15);
        tests++;
        if (strobes_r !== 4) begin
            fails++;
            $display("FAIL repeat_strobes got %0d want 4", strobes_r);
        end
        tests++;
        if (div_r !== 5'd20 || last_div_r !== 5'd20) begin
            fails++;
            $display("FAIL repeat_div got %0d last=%0d want 20", div_r, last_div_r);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        strobes    = 0;
        strobes_r  = 0;
        last_div   = '0;
        last_div_r = '0;
        rst_n      = 1'b0;
        busy       = 1'b0;
        btn_up     = 1'b0;
        btn_dn     = 1'b0;
        test_reset();
        test_press();
        test_saturate();
        test_busy();
        test_cancel();
        test_reset_mid();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_div_cfg.md
# led_div_cfg

Upstream configuration stage for the LED counter partial-reconfiguration region. Two raw push-buttons step a 5-bit divider value up or down. The block drives the divider bus and a one-cycle write strobe directly into the wrapper's `div_i` / `wren_i`. Writes are deferred while the reconfigurable partition is busy, so the counter never misses the final value.

## Interface
- `DEBOUNCE_CYC`, default 1000000: cycles a button level must stay stable before it is accepted (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_CYC`, default 25000000: auto-repeat period while a button is held (250 ms); 0 disables repeat.
- `DIV_RST`, default 5'd16: divider value loaded at reset.
- `clk100`  in  1  the single clock, 100 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_up_i`  in  1  raw, asynchronous button, active-high; increments.
- `btn_dn_i`  in  1  raw, asynchronous button, active-high; decrements.
- `pr_busy_i`  in  1  high while the downstream partition is reconfiguring; writes are held off.
- `div_o`  out  5  current divider value; connects to `div_i`.
- `wren_o`  out  1  one-cycle write strobe; connects to `wren_i`.
- `pend_o`  out  1  high while a changed value awaits its write.

## Operation
- **Input sync:** each button passes through a 2-FF synchronizer.
- **Debounce:**
  - One counter per button resets whenever the synced level equals the accepted (stable) level.
  - When the synced level differs from the stable level for `DEBOUNCE_CYC` consecutive cycles, the stable level takes the synced level and the counter clears.
- **Step event:**
  - A rising edge of the stable level produces one event.
  - While the stable level is held high and `REPEAT_CYC` ≠ 0, a repeat counter produces one event every `REPEAT_CYC` cycles after the press event.
  - The repeat counter clears on release.
- **Arithmetic:**
  - An up event gives `div_o`+1, saturating at 31.
  - A down event gives `div_o`−1, saturating at 0.
  - Up and down events in the same cycle cancel: no change.
  - A saturated event is not a change.
- **Write FSM:** states WAIT, WRITE, IDLE.
  - IDLE: a change with `pr_busy_i`=0 goes to WRITE; a change with `pr_busy_i`=1 goes to WAIT.
  - WAIT: when `pr_busy_i`=0, go to WRITE. Further changes in WAIT update `div_o` and stay in WAIT, so only the final value is written.
  - WRITE: `wren_o`=1 for exactly one cycle, regardless of `pr_busy_i` in that cycle. Then:
    - a new change with busy=0 goes to WRITE again (back-to-back strobe);
    - a new change with busy=1 goes to WAIT;
    - otherwise go to IDLE.
  - `pend_o` = (state == WAIT).
- **Reset:**
  - Values: state = WAIT, `div_o` = `DIV_RST`, `wren_o` = 0, `pend_o` = 1, stable levels = 0, all counters = 0.
  - The first cycle after reset deassertion with `pr_busy_i`=0 therefore writes `DIV_RST` once, which initialises the downstream block.
  - Asserting `rst_n` mid-operation aborts any pending or in-progress write immediately; no strobe is emitted during reset.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Latency:**
  - Raw button edge to stable-level change: 2 sync cycles + `DEBOUNCE_CYC`.
  - Event (cycle N) to updated `div_o` plus `wren_o` high: cycle N+1, when not busy.
  - `div_o` is always valid in the cycle `wren_o`=1 and stays stable until the next event.
- **Busy:** `pr_busy_i` is sampled in the same cycle as the decision. A falling `pr_busy_i` in cycle M gives `wren_o` in cycle M+1.
- **Counter width:** `$clog2(max(DEBOUNCE_CYC, REPEAT_CYC)+1)`.

## Structure
- Package `led_cfg_pkg`:
  - `DIV_W` = 5 and `DIV_MAX` = 31;
  - write-FSM state enum `wr_state_t` {IDLE, WAIT, WRITE}.
- Sub-module `btn_debounce` (synchronizer, debounce counter, edge detect, auto-repeat; output `event_o`), instantiated twice with `DEBOUNCE_CYC` / `REPEAT_CYC` passed through.
- The top level holds the divider register and the write FSM.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `REPEAT_CYC`=0, `DIV_RST`=16 unless stated.
- Release reset with busy=0 → `wren_o` high for exactly 1 cycle, with `div_o`=16; `pend_o` falls with it.
- Clean up press held 10 cycles → one strobe, with `div_o`=17. A 3-cycle glitch pulse → no event, `div_o` unchanged.
- Set `div_o`=31, then press up → no strobe, `div_o`=31. Set `div_o`=0, then press down → no strobe.
- Hold busy=1 and issue three up presses from 16 → `pend_o`=1 and `div_o`=19, no strobe. Drop busy → single strobe one cycle later with `div_o`=19.
- Up and down debounced events in the same cycle → no change, no strobe. With `REPEAT_CYC`=20, hold up for 70 cycles after acceptance → 4 events, `div_o`=20, 4 strobes.
- Assert `rst_n` in the WAIT state with `div_o`=22 → outputs immediately return to `div_o`=16, `wren_o`=0, `pend_o`=1.
